// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch (inst) and
// mem-stage (data) requesters. At most one transaction is outstanding; data
// wins ties. Results are held in per-requester registers with done flags
// that drop once the pipeline advances.
//
// Ports
//   clk, resetn          clock, async active-low reset
//   inst_req/addr        fetch read request
//   inst_rdata/stall     held instruction word, fetch not complete
//   data_req/wr/wstrb/addr/wdata  data access request
//   data_rdata/stall     held load data, data access not complete
//   pipe_stall           0 = pipeline advances this cycle (clears done flags)
//   flush                cancels pending and unissued accesses
//   mem_*                shared memory request / handshake / read data
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_stall,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_stall,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0] state;
  logic [1:0] stateNext;
  logic       ownerData;   // 1 = current transaction belongs to data port
  logic       discard;     // flushed after issue; drop the response
  logic       discardNext;
  logic       instDone;
  logic       dataDone;
  logic       instElig;
  logic       dataElig;
  logic       grant;
  logic       grantData;
  logic       keepResp;    // response arrives and is delivered to owner

  assign instElig   = inst_req & ~instDone;
  assign dataElig   = data_req & ~dataDone;
  assign inst_stall = inst_req & ~instDone;
  assign data_stall = data_req & ~dataDone;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      discard <= 1'b0;
    end else begin
      state   <= stateNext;
      discard <= discardNext;
    end
  end

  // Next-state, grant and response decode.
  always_comb begin
    stateNext   = state;
    discardNext = discard;
    grant       = 1'b0;
    grantData   = 1'b0;
    keepResp    = 1'b0;
    case (state)
      IDLE: begin
        discardNext = 1'b0;
        if (!flush && (instElig || dataElig)) begin
          grant     = 1'b1;
          grantData = dataElig;
          stateNext = ADDR;
        end
      end
      ADDR: begin
        if (mem_addr_ok) begin
          // Accepted by memory: must run to completion even if flushed.
          stateNext = WAIT;
          if (flush) discardNext = 1'b1;
        end else if (flush) begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          stateNext   = IDLE;
          keepResp    = ~discard & ~flush;
          discardNext = 1'b0;
        end else if (flush) begin
          discardNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Memory request fields, captured at grant and held through ADDR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wstrb <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      ownerData <= 1'b0;
    end else begin
      mem_req <= (stateNext == ADDR);
      if (grant) begin
        ownerData <= grantData;
        if (grantData) begin
          mem_wr    <= data_wr;
          mem_wstrb <= data_wr ? data_wstrb : 4'h0;
          mem_addr  <= data_addr;
          mem_wdata <= data_wdata;
        end else begin
          mem_wr    <= 1'b0;
          mem_wstrb <= 4'h0;
          mem_addr  <= inst_addr;
          mem_wdata <= 32'h0;
        end
      end
    end
  end

  // Done flags: clearing (pipeline advance or flush) wins over setting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      instDone <= 1'b0;
      dataDone <= 1'b0;
    end else begin
      if (flush || !pipe_stall)        instDone <= 1'b0;
      else if (keepResp && !ownerData) instDone <= 1'b1;
      if (flush || !pipe_stall)        dataDone <= 1'b0;
      else if (keepResp && ownerData)  dataDone <= 1'b1;
    end
  end

  // Holding registers; stores leave them untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rdata <= 32'h0;
      data_rdata <= 32'h0;
    end else if (keepResp && !mem_wr) begin
      if (ownerData) data_rdata <= mem_rdata;
      else           inst_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, arbitration, store, flush in ADDR
// and WAIT, reset mid-transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic        pipe_stall;
  logic        flush;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_stall(data_stall),
    .pipe_stall(pipe_stall), .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    pipe_stall = 1'b0; flush = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_mem_req",   32'(mem_req), 32'h0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_inst_rd",   inst_rdata, 32'h0);
    chk("rst_data_rd",   data_rdata, 32'h0);

    // Single fetch, immediate handshakes.
    resetn = 1'b1; inst_req = 1'b1; inst_addr = 32'hbfc00000; pipe_stall = 1'b1;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h3c1d0000;
    #1 chk("f_stall_c0", 32'(inst_stall), 32'h1);
    tick();
    chk("f_req_c1",   32'(mem_req), 32'h1);
    chk("f_addr_c1",  mem_addr, 32'hbfc00000);
    chk("f_wr_c1",    32'(mem_wr), 32'h0);
    tick();
    chk("f_req_c2",   32'(mem_req), 32'h0);
    chk("f_stall_c2", 32'(inst_stall), 32'h1);
    tick();
    chk("f_stall_c3", 32'(inst_stall), 32'h0);
    chk("f_rdata_c3", inst_rdata, 32'h3c1d0000);
    pipe_stall = 1'b0;
    tick();
    chk("f_clr_stall", 32'(inst_stall), 32'h1);
    chk("f_clr_req",   32'(mem_req), 32'h0);
    inst_req = 1'b0;
    tick();
    chk("f_idle_req",  32'(mem_req), 32'h0);

    // Simultaneous requests: data first, then inst back-to-back.
    inst_req = 1'b1; inst_addr = 32'hbfc00004;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000010;
    pipe_stall = 1'b1; mem_rdata = 32'h12345678;
    tick();
    chk("a_req_c1",   32'(mem_req), 32'h1);
    chk("a_addr_c1",  mem_addr, 32'h80000010);
    tick();
    tick();
    chk("a_drd_c3",   data_rdata, 32'h12345678);
    chk("a_dst_c3",   32'(data_stall), 32'h0);
    chk("a_ist_c3",   32'(inst_stall), 32'h1);
    mem_rdata = 32'h0badf00d;
    tick();
    chk("a_req_c4",   32'(mem_req), 32'h1);
    chk("a_addr_c4",  mem_addr, 32'hbfc00004);
    tick();
    chk("a_ist_c5",   32'(inst_stall), 32'h1);
    tick();
    chk("a_ist_c6",   32'(inst_stall), 32'h0);
    chk("a_ird_c6",   inst_rdata, 32'h0badf00d);
    chk("a_drd_c6",   data_rdata, 32'h12345678);
    chk("a_req_c6",   32'(mem_req), 32'h0);
    flush = 1'b1;
    tick();
    chk("a_fl_ist",   32'(inst_stall), 32'h1);
    chk("a_fl_dst",   32'(data_stall), 32'h1);
    chk("a_fl_req",   32'(mem_req), 32'h0);
    flush = 1'b0; inst_req = 1'b0; data_req = 1'b0; pipe_stall = 1'b0;
    tick();

    // Store held on the bus until addr_ok.
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3;
    data_addr = 32'h80000020; data_wdata = 32'hdeadbeef;
    pipe_stall = 1'b1; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    tick();
    chk("s_req_c1",   32'(mem_req), 32'h1);
    chk("s_wr_c1",    32'(mem_wr), 32'h1);
    chk("s_strb_c1",  32'(mem_wstrb), 32'h3);
    chk("s_wd_c1",    mem_wdata, 32'hdeadbeef);
    chk("s_addr_c1",  mem_addr, 32'h80000020);
    data_wdata = 32'h0;
    tick();
    chk("s_req_c2",   32'(mem_req), 32'h1);
    chk("s_wd_c2",    mem_wdata, 32'hdeadbeef);
    chk("s_strb_c2",  32'(mem_wstrb), 32'h3);
    mem_addr_ok = 1'b1;
    tick();
    chk("s_req_c3",   32'(mem_req), 32'h0);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hffff0000;
    tick();
    chk("s_dst_c4",   32'(data_stall), 32'h0);
    chk("s_drd_c4",   data_rdata, 32'h12345678);
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    mem_data_ok = 1'b0; pipe_stall = 1'b0;
    tick();

    // Flush in ADDR before acceptance.
    inst_req = 1'b1; inst_addr = 32'hbfc00008; pipe_stall = 1'b1;
    tick();
    chk("fa_req_c1",  32'(mem_req), 32'h1);
    chk("fa_addr_c1", mem_addr, 32'hbfc00008);
    flush = 1'b1;
    tick();
    chk("fa_req_c2",  32'(mem_req), 32'h0);
    chk("fa_ist_c2",  32'(inst_stall), 32'h1);
    tick();
    chk("fa_req_c3",  32'(mem_req), 32'h0);
    flush = 1'b0; inst_req = 1'b0;
    tick();

    // Flush in WAIT: response discarded, no grant until data_ok.
    inst_req = 1'b1; inst_addr = 32'hbfc0000c; mem_addr_ok = 1'b1;
    tick();
    chk("fw_addr_c1", mem_addr, 32'hbfc0000c);
    tick();
    chk("fw_req_c2",  32'(mem_req), 32'h0);
    flush = 1'b1; mem_addr_ok = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000030;
    tick();
    flush = 1'b0;
    chk("fw_req_c3",  32'(mem_req), 32'h0);
    tick();
    chk("fw_req_c4",  32'(mem_req), 32'h0);
    tick();
    chk("fw_req_c5",  32'(mem_req), 32'h0);
    mem_data_ok = 1'b1; mem_rdata = 32'hffffffff;
    tick();
    chk("fw_ird_c6",  inst_rdata, 32'h0badf00d);
    chk("fw_ist_c6",  32'(inst_stall), 32'h1);
    chk("fw_req_c6",  32'(mem_req), 32'h0);
    mem_data_ok = 1'b0;
    tick();
    chk("fw_req_c7",  32'(mem_req), 32'h1);
    chk("fw_addr_c7", mem_addr, 32'h80000030);
    mem_addr_ok = 1'b1;
    tick();
    chk("fw_req_c8",  32'(mem_req), 32'h0);

    // Reset while in WAIT, then a stray data_ok.
    resetn = 1'b0; mem_addr_ok = 1'b0;
    #1;
    chk("r_mem_req",  32'(mem_req), 32'h0);
    chk("r_mem_addr", mem_addr, 32'h0);
    chk("r_mem_wr",   32'(mem_wr), 32'h0);
    chk("r_mem_strb", 32'(mem_wstrb), 32'h0);
    chk("r_mem_wd",   mem_wdata, 32'h0);
    chk("r_inst_rd",  inst_rdata, 32'h0);
    chk("r_data_rd",  data_rdata, 32'h0);
    chk("r_dst",      32'(data_stall), 32'h1);
    inst_req = 1'b0; data_req = 1'b0;
    tick();
    resetn = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hffffffff;
    tick();
    chk("r_late_drd", data_rdata, 32'h0);
    chk("r_late_ird", inst_rdata, 32'h0);
    chk("r_late_req", 32'(mem_req), 32'h0);
    mem_data_ok = 1'b0;
    tick();
    chk("r_idle_req", 32'(mem_req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all address ports.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 inst_req  in  1  fetch stage requests an instruction word read.
REQ-005 inst_addr  in  ADDR_W  fetch address (word aligned).
REQ-006 inst_rdata  out  32  held instruction word; valid while inst_done=1.
REQ-007 inst_stall  out  1  fetch access not yet complete.
REQ-008 data_req  in  1  mem stage requests a data access.
REQ-009 data_wr  in  1  1=write, 0=read.
REQ-010 data_wstrb  in  4  byte enables for writes.
REQ-011 data_addr  in  ADDR_W  data address.
REQ-012 data_wdata  in  32  write data.
REQ-013 data_rdata  out  32  held load data; valid while data_done=1.
REQ-014 data_stall  out  1  data access not yet complete.
REQ-015 pipe_stall  in  1  global pipeline hold from hazard logic; 0 = pipeline advances this cycle.
REQ-016 flush  in  1  exception flush; cancels pending and unissued accesses.
REQ-017 mem_req, mem_wr, mem_wstrb[3:0], mem_addr[ADDR_W-1:0], mem_wdata[31:0]  out  shared single-port memory request.
REQ-018 mem_addr_ok  in  1  memory accepted request this cycle; mem_data_ok  in  1  read data/write ack returned; mem_rdata  in  32.

Function
REQ-019 FSM states SHALL be IDLE, ADDR (mem_req=1, awaiting mem_addr_ok), WAIT (awaiting mem_data_ok).
REQ-020 Eligible requester = req high and its done flag 0; in IDLE, with any eligible requester and flush=0, SHALL move to ADDR and latch owner; data SHALL win over inst when both eligible.
REQ-021 Request fields SHALL be registered at grant and held constant on mem_* outputs throughout ADDR; mem_req=1 only in ADDR.
REQ-022 ADDR with mem_addr_ok=1 SHALL go to WAIT next cycle; at most one outstanding transaction.
REQ-023 WAIT with mem_data_ok=1 SHALL return to IDLE, set owner done flag, load mem_rdata into owner holding register (writes: register unchanged).
REQ-024 Minimum latency: request in IDLE at cycle 0, addr_ok and data_ok each same cycle presented -> done flag high at cycle 3, stall low at cycle 3.
REQ-025 inst_stall = inst_req & ~inst_done; data_stall = data_req & ~data_done (combinational).
REQ-026 Done flags SHALL clear at a clock edge where pipe_stall=0; a flag set and cleared on the same edge SHALL end set=0 only if pipe_stall=0 already before completion cycle (clear wins).
REQ-027 flush in IDLE: no grant that cycle. flush in ADDR with mem_addr_ok=0: SHALL drop request, go IDLE, no mem_req next cycle. flush in ADDR with mem_addr_ok=1 or in WAIT: transaction SHALL complete to memory, mark discard; on mem_data_ok no done flag set, holding register unchanged.
REQ-028 flush SHALL clear both done flags on the same edge.
REQ-029 Back-to-back: IDLE after completion SHALL grant the other eligible requester next cycle, no idle gap beyond IDLE cycle.
REQ-030 mem_data_ok in IDLE/ADDR SHALL be ignored; mem_addr_ok outside ADDR ignored.

Reset
REQ-031 resetn=0 SHALL force IDLE, mem_req=0, mem_wr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, done flags=0, discard=0, inst_rdata=0, data_rdata=0.
REQ-032 Reset mid-transaction SHALL abandon it; late mem_data_ok after release ignored (state IDLE).

Verification
REQ-033 Single fetch: inst_req=1, addr 0xbfc00000, addr_ok/data_ok immediate, rdata 0x3c1d0000 -> mem_addr=0xbfc00000, inst_rdata=0x3c1d0000, inst_stall low at cycle 3.
REQ-034 Simultaneous inst_req and data_req (read 0x80000010, data 0x12345678) -> data granted first, then inst; data_rdata=0x12345678; inst_stall held until inst completes.
REQ-035 Store: data_wr=1, wstrb=0x3, addr 0x80000020, wdata 0xdeadbeef -> mem_wr=1, mem_wstrb=0x3, mem_wdata=0xdeadbeef held until addr_ok; data_rdata unchanged.
REQ-036 flush in ADDR with addr_ok=0 -> mem_req low next cycle, IDLE, no done flag.
REQ-037 flush in WAIT, data_ok 3 cycles later with 0xffffffff -> inst_rdata keeps old value, inst_done stays 0, next grant only after data_ok.
REQ-038 resetn low in WAIT -> all outputs at reset values; data_ok after release causes no change.
